// File: rtl/puf_resp_uart_tx.sv
// PUF response return path: latches each evaluation into a one-entry slot, frames it
// as A5 / chal_id / response / checksum, and sends it out 8N1.
module puf_resp_uart_tx #(
    parameter int CLOCK_FRE = 100000000,
    parameter int BAUD_RATE = 19200,
    parameter int K         = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         resp_ready,
    input  logic         resp_bit,
    input  logic [K-1:0] resp_bit_a,
    input  logic [7:0]   chal_id,
    input  logic         ovf_clr,
    output logic         tx,
    output logic         busy,
    output logic         overflow
);
    localparam int DIV = CLOCK_FRE / BAUD_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, stateNext;
    logic [CW-1:0]     baudCnt, baudCntNext;
    logic [2:0]        bitIdx, bitIdxNext;
    logic [1:0]        bytesLeft, bytesLeftNext;
    logic [7:0]        shiftReg, shiftRegNext;
    logic [2:0][7:0]   restBytes, restBytesNext;
    logic              slotFull, slotFullNext;
    logic [7:0]        slotId, slotIdNext;
    logic              slotBit, slotBitNext;
    logic [K-1:0]      slotA, slotANext;
    logic              txNext, busyNext, overflowNext;
    logic              baudDone, take, drop;
    logic [7:0]        b2, b3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            bytesLeft <= '0;
            shiftReg  <= '0;
            restBytes <= '0;
            slotFull  <= 1'b0;
            slotId    <= '0;
            slotBit   <= 1'b0;
            slotA     <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= stateNext;
            baudCnt   <= baudCntNext;
            bitIdx    <= bitIdxNext;
            bytesLeft <= bytesLeftNext;
            shiftReg  <= shiftRegNext;
            restBytes <= restBytesNext;
            slotFull  <= slotFullNext;
            slotId    <= slotIdNext;
            slotBit   <= slotBitNext;
            slotA     <= slotANext;
            tx        <= txNext;
            busy      <= busyNext;
            overflow  <= overflowNext;
        end
    end

    // Response byte: XOR bit in the MSB, APUF bits right-aligned, zero fill between.
    always_comb begin
        b2        = '0;
        b2[K-1:0] = slotA;
        b2[7]     = slotBit;
        b3        = 8'hA5 ^ slotId ^ b2;
    end

    always_comb begin
        stateNext     = state;
        baudCntNext   = baudCnt;
        bitIdxNext    = bitIdx;
        bytesLeftNext = bytesLeft;
        shiftRegNext  = shiftReg;
        restBytesNext = restBytes;
        slotFullNext  = slotFull;
        slotIdNext    = slotId;
        slotBitNext   = slotBit;
        slotANext     = slotA;
        txNext        = tx;
        overflowNext  = overflow;
        take          = 1'b0;
        drop          = 1'b0;
        baudDone      = (baudCnt == DIV_LAST);

        if (state != IDLE)
            baudCntNext = baudDone ? '0 : baudCnt + 1'b1;

        case (state)
            IDLE: if (slotFull) take = 1'b1;
            START: if (baudDone) begin
                stateNext  = DATA;
                bitIdxNext = '0;
                txNext     = shiftReg[0];
            end
            DATA: if (baudDone) begin
                if (bitIdx == 3'd7) begin
                    stateNext = STOP;
                    txNext    = 1'b1;
                end else begin
                    bitIdxNext   = bitIdx + 3'd1;
                    shiftRegNext = shiftReg >> 1;
                    txNext       = shiftReg[1];
                end
            end
            STOP: if (baudDone) begin
                if (bytesLeft != 2'd0) begin
                    stateNext     = START;
                    txNext        = 1'b0;
                    shiftRegNext  = restBytes[0];
                    restBytesNext = {8'h00, restBytes[2], restBytes[1]};
                    bytesLeftNext = bytesLeft - 2'd1;
                end else if (slotFull) begin
                    take = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (take) begin
            stateNext     = START;
            txNext        = 1'b0;
            baudCntNext   = '0;
            shiftRegNext  = 8'hA5;
            restBytesNext = {b3, b2, slotId};
            bytesLeftNext = 2'd3;
            slotFullNext  = 1'b0;
        end

        // A slot being emptied this edge can accept the incoming response.
        if (resp_ready) begin
            if (!slotFull || take) begin
                slotFullNext = 1'b1;
                slotIdNext   = chal_id;
                slotBitNext  = resp_bit;
                slotANext    = resp_bit_a;
            end else begin
                drop = 1'b1;
            end
        end

        if (ovf_clr) overflowNext = 1'b0;
        if (drop)    overflowNext = 1'b1;

        busyNext = (stateNext != IDLE) | slotFullNext;
    end
endmodule

// File: tb/tb_puf_resp_uart_tx.sv
// Directed bench for puf_resp_uart_tx: a UART monitor decodes tx and checks bytes
// against a scoreboard filled when each response pulse is driven.
module tb_puf_resp_uart_tx;
    localparam int K = 6;
    localparam int DIV = 16;
    localparam int FRAME = 40 * DIV;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         resp_ready = 1'b0;
    logic         resp_bit = 1'b0;
    logic [K-1:0] resp_bit_a = '0;
    logic [7:0]   chal_id = '0;
    logic         ovf_clr = 1'b0;
    logic         tx, busy, overflow;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit monEn = 1'b1;
    logic [7:0] monD;
    logic [7:0] q[$];

    puf_resp_uart_tx #(.CLOCK_FRE(160), .BAUD_RATE(10), .K(K)) dut (
        .clk(clk), .rst(rst), .resp_ready(resp_ready), .resp_bit(resp_bit),
        .resp_bit_a(resp_bit_a), .chal_id(chal_id), .ovf_clr(ovf_clr),
        .tx(tx), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one response pulse starting at a negedge; optionally pushes the expected frame.
    task automatic pulse(input logic [7:0] id, input logic rb, input logic [K-1:0] ra,
                         input bit push, input bit clr);
        logic [7:0] e2;
        e2 = {rb, 7'(ra)};
        if (push) begin
            q.push_back(8'hA5);
            q.push_back(id);
            q.push_back(e2);
            q.push_back(8'hA5 ^ id ^ e2);
        end
        chal_id = id; resp_bit = rb; resp_bit_a = ra; resp_ready = 1'b1; ovf_clr = clr;
        @(negedge clk);
        resp_ready = 1'b0; ovf_clr = 1'b0;
    endtask

    // Returns cycles elapsed from startCyc until busy is seen low (bounded).
    task automatic waitIdle(input int startCyc, output int len);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        len = cyc - startCyc;
    endtask

    always begin
        @(negedge clk);
        if (monEn && !rst && tx === 1'b0) begin
            repeat (DIV/2) @(negedge clk);
            chk("start_bit", 32'(tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                monD[i] = tx;
            end
            repeat (DIV) @(negedge clk);
            chk("stop_bit", 32'(tx), 32'd1);
            if (q.size() == 0) begin
                total++; bad++;
                $error("FAIL unexpected_byte observed=%0h expected=none", monD);
            end else begin
                chk("byte", 32'(monD), 32'(q.pop_front()));
            end
        end
    end

    initial begin
        int errs, s, len;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        // 1: quiet line
        errs = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) errs++;
        end
        chk("idle_1000", 32'(errs), 32'd0);

        // 2: single frame A5 3C A9 30
        pulse(8'h3C, 1'b1, 6'b101001, 1'b1, 1'b0);
        chk("t2_tx_pre", 32'(tx), 32'd1);
        chk("t2_busy_cap", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t2_tx_start", 32'(tx), 32'd0);
        s = cyc;
        waitIdle(s, len);
        chk("t2_len", 32'(len), 32'(FRAME));
        chk("t2_q_empty", 32'(q.size()), 32'd0);
        repeat (20) @(negedge clk);

        // 3: second pulse mid-frame, sent back-to-back
        pulse(8'h55, 1'b0, 6'h2A, 1'b1, 1'b0);
        @(negedge clk);
        s = cyc;
        repeat (100) @(negedge clk);
        pulse(8'h01, 1'b0, 6'h00, 1'b1, 1'b0);
        waitIdle(s, len);
        chk("t3_len", 32'(len), 32'(2 * FRAME));
        chk("t3_ovf", 32'(overflow), 32'd0);
        chk("t3_q_empty", 32'(q.size()), 32'd0);
        repeat (20) @(negedge clk);

        // 4: third pulse dropped; clear racing a drop keeps overflow set
        pulse(8'h10, 1'b1, 6'h3F, 1'b1, 1'b0);
        @(negedge clk);
        s = cyc;
        repeat (50) @(negedge clk);
        pulse(8'h20, 1'b0, 6'h15, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        chk("t4_ovf_before", 32'(overflow), 32'd0);
        pulse(8'h30, 1'b1, 6'h01, 1'b0, 1'b0);
        chk("t4_ovf_set", 32'(overflow), 32'd1);
        repeat (10) @(negedge clk);
        pulse(8'h40, 1'b1, 6'h02, 1'b0, 1'b1);
        chk("t4_ovf_set_wins", 32'(overflow), 32'd1);
        waitIdle(s, len);
        chk("t4_len", 32'(len), 32'(2 * FRAME));
        chk("t4_q_empty", 32'(q.size()), 32'd0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        repeat (20) @(negedge clk);

        // 5: reset mid-frame
        monEn = 1'b0;
        pulse(8'h66, 1'b1, 6'h11, 1'b0, 1'b0);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_tx_rst", 32'(tx), 32'd1);
        chk("t5_busy_rst", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_tx_idle", 32'(tx), 32'd1);
        monEn = 1'b1;
        pulse(8'h77, 1'b0, 6'h2C, 1'b1, 1'b0);
        @(negedge clk);
        chk("t5_tx_start", 32'(tx), 32'd0);
        s = cyc;
        waitIdle(s, len);
        chk("t5_len", 32'(len), 32'(FRAME));
        chk("t5_q_empty", 32'(q.size()), 32'd0);
        repeat (20) @(negedge clk);

        // 6: pulse on the final stop-bit edge with the slot empty
        pulse(8'h9A, 1'b1, 6'h07, 1'b1, 1'b0);
        @(negedge clk);
        s = cyc;
        errs = 0;
        while (cyc != s + FRAME - 1 && errs < 2000) begin
            @(negedge clk);
            errs++;
        end
        pulse(8'hC3, 1'b0, 6'h38, 1'b1, 1'b0);
        chk("t6_tx_idle_pass", 32'(tx), 32'd1);
        chk("t6_busy_held", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t6_tx_start", 32'(tx), 32'd0);
        s = cyc;
        waitIdle(s, len);
        chk("t6_len", 32'(len), 32'(FRAME));
        chk("t6_q_empty", 32'(q.size()), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        repeat (50) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
